// File: rtl/shift_exec_stage.sv
// shift_exec_stage: two-stage pipelined SLL/SRL/SRA shift unit built around a
// single right barrel shifter.
//   s1 registers the conditioned operand (bit-reversed for SLL, inverted for
//   negative SRA) together with op, amount and sign.
//   s2 applies the right shift, undoes the conditioning and registers the
//   result plus a zero flag.
// Optional feature macro: SHIFT_ROTATE_EN. When it is defined, op 2'b11 is ROR.
// When it is undefined, op 2'b11 behaves exactly like SRL and no rotate logic
// is built.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. in_ready depends only on pipeline state and out_ready, never on
// in_valid. While out_valid && !out_ready, every output holds stable.
module shift_exec_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int AMT_WIDTH  = 5
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_op,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [AMT_WIDTH-1:0]  in_amt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_result,
   output logic                  out_zero
);

   localparam logic [1:0] OP_SLL = 2'b00;
   localparam logic [1:0] OP_SRA = 2'b10;
`ifdef SHIFT_ROTATE_EN
   localparam logic [1:0] OP_ROR = 2'b11;
`endif

   function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] d);
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         r[i] = d[DATA_WIDTH-1-i];
      end
      return r;
   endfunction

   // Stage registers
   logic                  s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
   logic [1:0]            s1_op_q, s1_op_d;
   logic [AMT_WIDTH-1:0]  s1_amt_q, s1_amt_d;
   logic                  s1_neg_q, s1_neg_d;
   logic                  s2_valid_q, s2_valid_d;
   logic [DATA_WIDTH-1:0] s2_result_q, s2_result_d;
   logic                  s2_zero_q, s2_zero_d;

   logic                  s2_load;
   logic                  in_fire;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] stage2_result;

   // Pipeline control: s2 loads when empty or drained; s1 accepts when it is
   // empty or moving into s2
   always_comb begin
      s2_load  = !s2_valid_q || out_ready;
      in_ready = !s1_valid_q || s2_load;
      in_fire  = in_valid && in_ready;
   end

   // Stage 1: capture and condition the operand, or empty when advancing
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_data_d  = s1_data_q;
      s1_op_d    = s1_op_q;
      s1_amt_d   = s1_amt_q;
      s1_neg_d   = s1_neg_q;
      if (in_fire) begin
         s1_valid_d = 1'b1;
         s1_op_d    = in_op;
         s1_amt_d   = in_amt;
         s1_neg_d   = (in_op == OP_SRA) && in_data[DATA_WIDTH-1];
         case (in_op)
            OP_SLL:  s1_data_d = bit_rev(in_data);
            OP_SRA:  s1_data_d = in_data[DATA_WIDTH-1] ? ~in_data : in_data;
            default: s1_data_d = in_data;
         endcase
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage 2 datapath: one right shifter, then undo the stage 1 conditioning
   always_comb begin
      shifted = s1_data_q >> s1_amt_q;
      case (s1_op_q)
         OP_SLL:  stage2_result = bit_rev(shifted);
         OP_SRA:  stage2_result = s1_neg_q ? ~shifted : shifted;
`ifdef SHIFT_ROTATE_EN
         // At amt=0 the left term is forced to zero, so no full-width shift
         // ever feeds the result
         OP_ROR:  stage2_result = shifted |
                     ((s1_amt_q == '0) ? '0 :
                      (s1_data_q << ((AMT_WIDTH+1)'(DATA_WIDTH) - {1'b0, s1_amt_q})));
`endif
         default: stage2_result = shifted;
      endcase
   end

   // Stage 2 register update: load from s1 when allowed, otherwise hold
   always_comb begin
      s2_valid_d  = s2_valid_q;
      s2_result_d = s2_result_q;
      s2_zero_d   = s2_zero_q;
      if (s2_load) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            s2_result_d = stage2_result;
            s2_zero_d   = (stage2_result == '0);
         end
      end
   end

   // State registers with synchronous active-low reset dropping in-flight work
   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_op_q     <= '0;
         s1_amt_q    <= '0;
         s1_neg_q    <= 1'b0;
         s2_valid_q  <= 1'b0;
         s2_result_q <= '0;
         s2_zero_q   <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_op_q     <= s1_op_d;
         s1_amt_q    <= s1_amt_d;
         s1_neg_q    <= s1_neg_d;
         s2_valid_q  <= s2_valid_d;
         s2_result_q <= s2_result_d;
         s2_zero_q   <= s2_zero_d;
      end
   end

   assign out_valid  = s2_valid_q;
   assign out_result = s2_result_q;
   assign out_zero   = s2_zero_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Testbench for shift_exec_stage: directed checks followed by a randomized
// stream. The reference model computes each shift with plain arithmetic.
module tb_shift_exec_stage;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic        out_zero;

   int check_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   logic [31:0] exp_q[$];

   shift_exec_stage dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_data    (in_data),
      .in_amt     (in_amt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero)
   );

   // Clock and watchdog
   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Reference model: shift semantics in plain arithmetic
   function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                             input logic [4:0] amt);
`ifdef SHIFT_ROTATE_EN
      logic [63:0] dd;
`endif
      case (op)
         2'b00:   return d << amt;
         2'b01:   return d >> amt;
         2'b10:   return 32'($signed(d) >>> amt);
         default: begin
`ifdef SHIFT_ROTATE_EN
            dd = {d, d} >> amt;
            return dd[31:0];
`else
            return d >> amt;
`endif
         end
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One cycle with scoreboard: sample both handshakes on the falling edge
   task automatic sb_cycle(output bit acc, output bit del);
      logic [31:0] e;
      @(negedge clock);
      acc = in_valid && in_ready;
      del = out_valid && out_ready;
      if (del) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(out_valid), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("rand_result", out_result, e);
            check("rand_zero", 32'(out_zero), 32'(e == 32'd0));
         end
      end
      if (acc) exp_q.push_back(ref_shift(in_op, in_data, in_amt));
      @(posedge clock);
      #1;
   endtask

   // Single request with out_ready high; the result appears two edges after
   // the request is presented (s1 capture, then s2 capture)
   task automatic send_one(input string tag, input logic [1:0] op, input logic [31:0] d,
                           input logic [4:0] amt, input logic [31:0] exp);
      out_ready = 1'b1;
      in_op     = op;
      in_data   = d;
      in_amt    = amt;
      in_valid  = 1'b1;
      #1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check({tag, "_not_yet"}, 32'(out_valid), 32'd0);
      tick();
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_result"}, out_result, exp);
      check({tag, "_zero"}, 32'(out_zero), 32'(exp == 32'd0));
      tick();
      check({tag, "_drained"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      bit acc;
      bit del;
      int sent;
      int cyc;
      int n_in;
      int n_out;

      // Reset
      reset     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 2'b00;
      in_data   = 32'd0;
      in_amt    = 5'd0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_result", out_result, 32'd0);
      check("rst_out_zero", 32'(out_zero), 32'd0);
      reset = 1'b1;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // Directed shifts and boundaries
      send_one("sll_1_31", 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000);
      send_one("sra_neg_4", 2'b10, 32'h8000_0000, 5'd4, 32'hF800_0000);
      send_one("sra_pos_31", 2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000);
      send_one("srl_28", 2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F);
      send_one("sll_amt0", 2'b00, 32'h1234_5678, 5'd0, 32'h1234_5678);
      send_one("sra_amt0", 2'b10, 32'h8765_4321, 5'd0, 32'h8765_4321);
`ifdef SHIFT_ROTATE_EN
      send_one("ror_1_1", 2'b11, 32'h0000_0001, 5'd1, 32'h8000_0000);
`else
      send_one("ror_1_1", 2'b11, 32'h0000_0001, 5'd1, 32'h0000_0000);
`endif
      send_one("ror_amt0", 2'b11, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);

      // Backpressure: three back-to-back requests with out_ready low
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op = 2'b00; in_data = 32'h0000_0003; in_amt = 5'd2;
      #1;
      check("bp_rdy_a", 32'(in_ready), 32'd1);
      tick();
      in_op = 2'b01; in_data = 32'h0000_0100; in_amt = 5'd4;
      #1;
      check("bp_rdy_b", 32'(in_ready), 32'd1);
      tick();
      in_op = 2'b10; in_data = 32'hFFFF_FF00; in_amt = 5'd8;
      #1;
      check("bp_valid_a", 32'(out_valid), 32'd1);
      check("bp_result_a", out_result, 32'h0000_000C);
      check("bp_rdy_c_blocked", 32'(in_ready), 32'd0);
      for (int i = 0; i < 2; i++) begin
         tick();
         check("bp_hold_valid", 32'(out_valid), 32'd1);
         check("bp_hold_result", out_result, 32'h0000_000C);
         check("bp_hold_zero", 32'(out_zero), 32'd0);
         check("bp_hold_rdy", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp_rdy_release", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("bp_result_b", out_result, 32'h0000_0010);
      check("bp_valid_b", 32'(out_valid), 32'd1);
      tick();
      check("bp_result_c", out_result, 32'hFFFF_FFFF);
      check("bp_valid_c", 32'(out_valid), 32'd1);
      tick();
      check("bp_drained", 32'(out_valid), 32'd0);

      // Reset with both stages full drops everything
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op = 2'b01; in_data = 32'hAAAA_0000; in_amt = 5'd1;
      tick();
      in_data = 32'h5555_0000;
      tick();
      in_valid = 1'b0;
      check("full_before_rst", 32'(out_valid), 32'd1);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      #1;
      check("rst2_out_valid", 32'(out_valid), 32'd0);
      check("rst2_out_result", out_result, 32'd0);
      check("rst2_out_zero", 32'(out_zero), 32'd0);
      check("rst2_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst2_no_ghost", 32'(out_valid), 32'd0);
      end

      // Randomized stream with random backpressure
      sent = 0;
      cyc  = 0;
      while ((sent < 100 || exp_q.size() != 0) && cyc < 3000) begin
         if (!in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_data  = $urandom();
            in_amt   = 5'($urandom_range(0, 31));
         end
         out_ready = ($urandom_range(0, 2) != 0);
         sb_cycle(acc, del);
         if (acc) begin
            sent++;
            in_valid = 1'b0;
         end
         cyc++;
      end
      in_valid = 1'b0;
      check("rand_sent", 32'(sent), 32'd100);
      check("rand_drained", 32'(exp_q.size()), 32'd0);

      // Full throughput: one request and one result per cycle
      out_ready = 1'b1;
      n_in  = 0;
      n_out = 0;
      for (int i = 0; i < 22; i++) begin
         if (i < 20) begin
            in_valid = 1'b1;
            in_op    = 2'($urandom_range(0, 3));
            in_data  = $urandom();
            in_amt   = 5'($urandom_range(0, 31));
         end else begin
            in_valid = 1'b0;
         end
         sb_cycle(acc, del);
         if (acc) n_in++;
         if (del) n_out++;
      end
      check("tput_in", 32'(n_in), 32'd20);
      check("tput_out", 32'(n_out), 32'd20);
      check("tput_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
